// File: rtl/kw_ror_iter.sv
// kw_ror_iter -- iterative rotate-right unit.
// Accepts one operand/amount pair, then applies one power-of-two rotate
// stage per cycle (AW stages, fixed latency) and presents the result until
// it is consumed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   high only when idle (request can be accepted)
//   in_data    operand, WIDTH bits
//   in_amt     rotate-right amount, AW bits
//   out_valid  high only when the result is presented
//   out_ready  consumer accepts the result
//   out_data   rotated result, WIDTH bits
//   busy       high while an operation is in flight or awaiting handshake
module kw_ror_iter #(
  parameter int WIDTH = 8,
  parameter int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int KW = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   data_r;
  logic [AW-1:0]      amt_r;
  logic [KW-1:0]      k;
  logic               last_stage;

  logic [31:0]        sh;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;

  // Stage k rotates by 2^k reduced modulo WIDTH, so amounts >= WIDTH
  // fold back naturally for non-power-of-two widths.
  always_comb begin
    sh  = (32'd1 << k) % 32'(WIDTH);
    dbl = {data_r, data_r} >> sh;
    rot = dbl[WIDTH-1:0];
  end

  assign last_stage = (k == KW'(AW - 1));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_stage) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_r <= '0;
      amt_r  <= '0;
      k      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            amt_r  <= in_amt;
            k      <= '0;
          end
        end
        BUSY: begin
          if (amt_r[k]) data_r <= rot;
          k <= last_stage ? '0 : k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = data_r;

endmodule

// File: doc/kw_ror_iter.md
KW_ROR_ITER -- requirements
Module: kw_ror_iter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: data width in bits; the legal range is WIDTH >= 1.
REQ-002 The module SHALL have parameter AW, default max(1, clog2(WIDTH)): rotate-amount width and stage count.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: request valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: operand.
REQ-008 The module SHALL have port in_amt, input, AW bits: rotate-right amount.
REQ-009 The module SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The module SHALL have port out_data, output, WIDTH bits: rotated result.
REQ-012 The module SHALL have port busy, output, 1 bit: high in BUSY or DONE.

Function
REQ-013 The result SHALL equal in_data rotated right by (in_amt mod WIDTH): out_data[i] = in_data[(i + in_amt) mod WIDTH].
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL equal 1 only in IDLE.
REQ-016 out_valid SHALL equal 1 only in DONE.
REQ-017 On an edge with IDLE and in_valid=1, the block SHALL register in_data and in_amt, clear the stage counter k to 0 and go to BUSY.
REQ-018 In IDLE with in_valid=0, the FSM SHALL hold its state.
REQ-019 In BUSY, each edge SHALL apply one static rotate-right stage: if amt[k]=1, the data register rotates right by 2^k (modulo WIDTH); otherwise it is held.
REQ-020 In BUSY, k SHALL increment each cycle; the edge processing k = AW-1 SHALL go to DONE.
REQ-021 Latency SHALL be fixed at exactly AW cycles from the accept edge to out_valid=1, independent of the amount value, with no early exit.
REQ-022 In DONE, out_data and out_valid SHALL hold stable until out_ready=1.
REQ-023 On an edge with DONE and out_ready=1, the FSM SHALL go to IDLE.
REQ-024 At most one request SHALL be in flight; a new request is accepted no earlier than the cycle after the output handshake.
REQ-025 in_valid, in_data and in_amt SHALL be ignored outside IDLE.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 An in_amt value >= WIDTH (non-power-of-two WIDTH) SHALL reduce modulo WIDTH implicitly through the stage rotations.
REQ-028 When WIDTH=1, the output SHALL equal the input, with latency 1.
REQ-029 in_ready SHALL be independent of in_valid, and out_valid SHALL be independent of out_ready (no combinational paths between them).

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, out_data=0 and k=0.
REQ-031 Reset assertion SHALL take effect immediately, without a clock.
REQ-032 Reset mid-BUSY or mid-DONE SHALL discard the in-flight operation, with no output handshake afterwards.
REQ-033 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-034 The bench SHALL cover this case: WIDTH=8, in_data=0xB4, in_amt=3, out_ready=1 -> out_data=0x96, out_valid=1 exactly 3 cycles after accept.
REQ-035 The bench SHALL cover this case: WIDTH=8, in_data=0x01, in_amt=7 -> out_data=0x02; and in_amt=0 -> out_data=in_data, same 3-cycle latency.
REQ-036 The bench SHALL cover this case: WIDTH=6, in_data=6'b000001, in_amt=7 -> out_data=6'b100000 (amount 1).
REQ-037 The bench SHALL cover this case: hold out_ready=0 for 5 cycles in DONE while driving new in_valid and data -> out_data stable, in_ready=0, nothing accepted; release -> IDLE next cycle.
REQ-038 The bench SHALL cover this case: assert rst_n=0 asynchronously during BUSY stage 1 -> out_valid=0 and in_ready=1 immediately; the next request completes correctly.
REQ-039 The bench SHALL cover this case: back-to-back requests with in_valid and out_ready held at 1 -> one accept per AW+2 cycles, and results match the REQ-013 model for random data/amount over 1000 trials.
